// File: rtl/itu656_encoder_pkg.sv
// Shared BT.656 encoder definitions: timing-reference bytes, fill levels,
// payload clamp limits, the byte-region type and the protection-bit encoder.
package itu656_pkg;

  localparam logic [7:0] TRS_0    = 8'hFF;
  localparam logic [7:0] TRS_1    = 8'h00;
  localparam logic [7:0] TRS_2    = 8'h00;
  localparam logic [7:0] BLANK_C  = 8'h80;
  localparam logic [7:0] BLANK_Y  = 8'h10;
  localparam logic [7:0] CLAMP_LO = 8'h01;
  localparam logic [7:0] CLAMP_HI = 8'hFE;

  typedef enum logic [1:0] {
    EAV,
    HBLANK,
    SAV,
    ACTIVE
  } region_t;

  // Fourth byte of EAV/SAV: fixed MSB, F/V/H, then the Hamming protection bits.
  function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Payload bytes must never collide with the 00/FF timing-reference values.
  function automatic logic [7:0] clamp_payload(input logic [7:0] b);
    if (b == 8'h00) return CLAMP_LO;
    if (b == 8'hFF) return CLAMP_HI;
    return b;
  endfunction

endpackage

// File: rtl/itu656_encoder_if.sv
// Pixel-word stream from the frame-buffer read FIFO into the encoder.
interface itu656_encoder_if;
  logic [15:0] iYCbCr;
  logic        iDVAL;
  logic        oREADY;

  modport master (output iYCbCr, output iDVAL, input oREADY);
  modport slave  (input iYCbCr, input iDVAL, output oREADY);
endinterface

// File: rtl/itu656_encoder_timing.sv
// Line/byte position counters with field, vertical-blank and region decode.
module itu656_timing
  import itu656_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 1716,
  parameter int unsigned ACT_BYTES  = 1440,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned F2_START   = 266,
  parameter int unsigned F2_END     = 3,
  parameter int unsigned VB1_END    = 19,
  parameter int unsigned VB2_START  = 264,
  parameter int unsigned VB2_END    = 282,
  parameter int unsigned HC_W       = $clog2(LINE_BYTES),
  parameter int unsigned LN_W       = $clog2(V_TOTAL + 1)
) (
  input  logic            iCLK,
  input  logic            iRST,
  output logic [HC_W-1:0] hc,
  output logic            f,
  output logic            v,
  output logic            hblank,
  output logic            frame_origin,
  output region_t         region
);

  localparam int unsigned ACT_START = LINE_BYTES - ACT_BYTES;
  localparam int unsigned SAV_START = ACT_START - 4;

  logic [LN_W-1:0] ln;

  // Byte counter wraps each line; line counter runs 1..V_TOTAL.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hc <= '0;
      ln <= LN_W'(1);
    end else if (hc == HC_W'(LINE_BYTES - 1)) begin
      hc <= '0;
      ln <= (ln == LN_W'(V_TOTAL)) ? LN_W'(1) : ln + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Field/blanking flags and the byte region for the current position.
  always_comb begin
    f            = (ln >= LN_W'(F2_START)) || (ln <= LN_W'(F2_END));
    v            = (ln <= LN_W'(VB1_END)) ||
                   ((ln >= LN_W'(VB2_START)) && (ln <= LN_W'(VB2_END)));
    hblank       = (hc < HC_W'(ACT_START));
    frame_origin = (hc == '0) && (ln == LN_W'(1));
    if (hc < HC_W'(4))              region = EAV;
    else if (hc < HC_W'(SAV_START)) region = HBLANK;
    else if (hc < HC_W'(ACT_START)) region = SAV;
    else                            region = ACTIVE;
  end

endmodule

// File: rtl/itu656_encoder.sv
// BT.656 byte-stream generator: timing codes, blanking fill and clamped
// active video pulled from an upstream FIFO without ever stalling.
module itu656_encoder
  import itu656_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 1716,
  parameter int unsigned ACT_BYTES  = 1440,
  parameter int unsigned V_TOTAL    = 525,
  parameter int unsigned F2_START   = 266,
  parameter int unsigned F2_END     = 3,
  parameter int unsigned VB1_END    = 19,
  parameter int unsigned VB2_START  = 264,
  parameter int unsigned VB2_END    = 282
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iEN,
  itu656_encoder_if.slave   pix,
  output logic [7:0]        oTD_DATA,
  output logic              oF,
  output logic              oV,
  output logic              oH,
  output logic              oFRAME_START,
  output logic              oUNDERFLOW
);

  localparam int unsigned HC_W = $clog2(LINE_BYTES);

  logic [HC_W-1:0] hc;
  logic            f, v, hblank, frame_origin;
  region_t         region;

  logic            frame_en;
  logic            act_line;
  logic            ready;
  logic [7:0]      td_next;
  logic [7:0]      y_hold;
  logic            y_ok;
  logic            y_load;
  logic            uf_set;

  itu656_timing #(
    .LINE_BYTES (LINE_BYTES),
    .ACT_BYTES  (ACT_BYTES),
    .V_TOTAL    (V_TOTAL),
    .F2_START   (F2_START),
    .F2_END     (F2_END),
    .VB1_END    (VB1_END),
    .VB2_START  (VB2_START),
    .VB2_END    (VB2_END),
    .HC_W       (HC_W)
  ) u_timing (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .hc           (hc),
    .f            (f),
    .v            (v),
    .hblank       (hblank),
    .frame_origin (frame_origin),
    .region       (region)
  );

  assign pix.oREADY = ready;

  // Byte mux: TRS codes, 80/10 fill by byte parity, or chroma/luma payload.
  always_comb begin
    act_line = ~v & frame_en;
    ready    = act_line && (region == ACTIVE) && !hc[0];
    td_next  = hc[0] ? BLANK_Y : BLANK_C;
    y_load   = 1'b0;
    uf_set   = 1'b0;
    unique case (region)
      EAV, SAV: begin
        unique case (hc[1:0])
          2'd0:    td_next = TRS_0;
          2'd1:    td_next = TRS_1;
          2'd2:    td_next = TRS_2;
          default: td_next = xy_code(f, v, region == EAV);
        endcase
      end
      HBLANK: ;
      ACTIVE: begin
        if (act_line) begin
          if (!hc[0]) begin
            if (pix.iDVAL) begin
              td_next = clamp_payload(pix.iYCbCr[7:0]);
              y_load  = 1'b1;
            end else begin
              uf_set  = 1'b1;
            end
          end else if (y_ok) begin
            td_next = y_hold;
          end
        end
      end
    endcase
  end

  // Output register, flags, frame-enable latch and the luma holding register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oTD_DATA     <= BLANK_C;
      oF           <= 1'b1;
      oV           <= 1'b1;
      oH           <= 1'b0;
      oFRAME_START <= 1'b0;
      oUNDERFLOW   <= 1'b0;
      frame_en     <= 1'b0;
      y_hold       <= '0;
      y_ok         <= 1'b0;
    end else begin
      oTD_DATA     <= td_next;
      oF           <= f;
      oV           <= v;
      oH           <= hblank;
      oFRAME_START <= frame_origin;
      if (uf_set)       oUNDERFLOW <= 1'b1;
      if (frame_origin) frame_en   <= iEN;
      if (y_load)       y_hold     <= clamp_payload(pix.iYCbCr[15:8]);
      y_ok         <= y_load;
    end
  end

endmodule

// File: tb/tb_itu656_encoder.sv
// Randomised scoreboard bench for itu656_encoder against a line/byte
// arithmetic reference model.
module tb_itu656_encoder;

  // Short lines keep full-frame runs affordable; vertical timing is NTSC default.
  localparam int LB   = 40;
  localparam int ACT  = 16;
  localparam int VT   = 525;
  localparam int F2S  = 266;
  localparam int F2E  = 3;
  localparam int VB1E = 19;
  localparam int VB2S = 264;
  localparam int VB2E = 282;
  localparam int ACT0 = LB - ACT;
  localparam int SAV0 = ACT0 - 4;
  localparam int FR   = LB * VT;

  typedef struct {
    logic [7:0] d;
    logic       f, v, h, fs, uf;
    int         k;
    int         epoch;
    bit         is_rst;
  } exp_t;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iEN  = 1'b1;
  logic [7:0] oTD_DATA;
  logic       oF, oV, oH, oFRAME_START, oUNDERFLOW;

  itu656_encoder_if pix ();

  itu656_encoder #(
    .LINE_BYTES (LB),
    .ACT_BYTES  (ACT),
    .V_TOTAL    (VT),
    .F2_START   (F2S),
    .F2_END     (F2E),
    .VB1_END    (VB1E),
    .VB2_START  (VB2S),
    .VB2_END    (VB2E)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iEN          (iEN),
    .pix          (pix),
    .oTD_DATA     (oTD_DATA),
    .oF           (oF),
    .oV           (oV),
    .oH           (oH),
    .oFRAME_START (oFRAME_START),
    .oUNDERFLOW   (oUNDERFLOW)
  );

  always #5 iCLK = ~iCLK;

  int          total = 0;
  int          bad   = 0;
  exp_t        q[$];
  logic [15:0] dir_q[$];

  // Reference model state.
  int         k = 0;
  int         epoch = 0;
  bit         in_rst = 0;
  bit         fen = 0;
  bit         ypend = 0;
  bit         uf = 0;
  logic [7:0] yval = 8'h00;
  int         rdy_line = 0;

  // Script controls.
  bit rst_req = 1;
  bit en_req  = 1;
  bit rand_gap = 0;

  task automatic check(input string name, input int act, input int req, input int kk);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at k=%0d: got %0h want %0h", name, kk, act, req);
    end
  endtask

  function automatic logic [7:0] cl(input logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    if (b == 8'hFF) return 8'hFE;
    return b;
  endfunction

  function automatic logic [7:0] xy(input bit f, input bit v, input bit h);
    int s;
    s = 128 + f*64 + v*32 + h*16 + (v^h)*8 + (f^h)*4 + (f^v)*2 + (f^v^h);
    return s[7:0];
  endfunction

  function automatic logic [7:0] trs(input int i, input logic [7:0] x);
    if (i == 0) return 8'hFF;
    if (i == 3) return x;
    return 8'h00;
  endfunction

  function automatic logic [7:0] rb();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 8'h00;
    if (r == 1) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

  // Known-good bytes for the first run after reset, indexed by edge number.
  function automatic bit lookup(input int kk, output logic [7:0] val);
    lookup = 1;
    val    = 8'h00;
    case (kk)
      0:                 val = 8'hFF;
      1, 2:              val = 8'h00;
      3:                 val = 8'hF1;
      4:                 val = 8'h80;
      5:                 val = 8'h10;
      19*LB + 3:         val = 8'h9D;
      19*LB + SAV0 + 3:  val = 8'h80;
      19*LB + ACT0 + 0:  val = 8'h80;
      19*LB + ACT0 + 1:  val = 8'h5A;
      19*LB + ACT0 + 2:  val = 8'hF0;
      19*LB + ACT0 + 3:  val = 8'hEB;
      19*LB + ACT0 + 4:  val = 8'h01;
      19*LB + ACT0 + 5:  val = 8'hFE;
      19*LB + ACT0 + 6:  val = 8'h01;
      19*LB + ACT0 + 7:  val = 8'h01;
      19*LB + ACT0 + 8:  val = 8'hFE;
      19*LB + ACT0 + 9:  val = 8'hFE;
      29*LB + ACT0 + 6:  val = 8'h80;
      29*LB + ACT0 + 7:  val = 8'h10;
      263*LB + 3:        val = 8'hB6;
      282*LB + 3:        val = 8'hDA;
      282*LB + SAV0 + 3: val = 8'hC7;
      default:           lookup = 0;
    endcase
  endfunction

  // One clock: drive inputs after the falling edge, then predict the next edge.
  task automatic cycle();
    int          hc, ln;
    bit          fb, vb, act, er, dv;
    logic [15:0] w;
    logic [7:0]  d;
    exp_t        e;
    @(negedge iCLK);
    #1;
    hc = k % LB;
    ln = (k / LB) % VT + 1;
    if (dir_q.size() > 0) begin
      w  = dir_q[0];
      dv = 1;
    end else begin
      w  = {rb(), rb()};
      dv = rand_gap ? ($urandom_range(0, 5) != 0) : 1'b1;
    end
    if (!rand_gap && ln == 30 && hc == ACT0 + 6) dv = 0;
    pix.iYCbCr = w;
    pix.iDVAL  = dv;
    iRST       = rst_req;
    iEN        = en_req;
    #1;
    if (iRST) begin
      if (!in_rst) epoch++;
      in_rst   = 1;
      k        = 0;
      fen      = 0;
      ypend    = 0;
      uf       = 0;
      rdy_line = 0;
      check("ready_in_reset", pix.oREADY, 0, k);
      e = '{d: 8'h80, f: 1, v: 1, h: 0, fs: 0, uf: 0, k: 0, epoch: epoch, is_rst: 1};
      q.push_back(e);
    end else begin
      in_rst = 0;
      if (hc == 0 && ln == 1) fen = iEN;
      fb  = (ln >= F2S) || (ln <= F2E);
      vb  = (ln <= VB1E) || (ln >= VB2S && ln <= VB2E);
      act = !vb && fen;
      er  = act && hc >= ACT0 && ((hc - ACT0) % 2 == 0);
      check("ready", pix.oREADY, er, k);
      if (pix.oREADY) rdy_line++;
      if (hc == LB - 1) begin
        if (act) check("words_per_line", rdy_line, ACT / 2, k);
        rdy_line = 0;
      end
      if (hc < 4)                   d = trs(hc, xy(fb, vb, 1));
      else if (hc < SAV0)           d = (hc % 2) ? 8'h10 : 8'h80;
      else if (hc < ACT0)           d = trs(hc - SAV0, xy(fb, vb, 0));
      else if (!act)                d = (hc % 2) ? 8'h10 : 8'h80;
      else if ((hc - ACT0) % 2 == 0) begin
        if (dv) begin
          d     = cl(w[7:0]);
          yval  = cl(w[15:8]);
          ypend = 1;
        end else begin
          d     = 8'h80;
          ypend = 0;
          uf    = 1;
        end
      end else begin
        d = ypend ? yval : 8'h10;
      end
      if (er && dir_q.size() > 0) void'(dir_q.pop_front());
      e = '{d: d, f: fb, v: vb, h: (hc < ACT0), fs: (hc == 0 && ln == 1), uf: uf,
            k: k, epoch: epoch, is_rst: 0};
      q.push_back(e);
      k++;
    end
  endtask

  task automatic run_to(input int target);
    while (k < target) cycle();
  endtask

  // Monitor: compare each registered output against the oldest prediction.
  initial begin
    exp_t       e;
    logic [7:0] tv;
    int         n = 0;
    int         last_fs = -1;
    forever begin
      @(negedge iCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n++;
        check("td_data", oTD_DATA, e.d, e.k);
        check("f_bit", oF, e.f, e.k);
        check("v_bit", oV, e.v, e.k);
        check("h_bit", oH, e.h, e.k);
        check("frame_start", oFRAME_START, e.fs, e.k);
        check("underflow", oUNDERFLOW, e.uf, e.k);
        if (!e.is_rst && e.epoch == 1 && lookup(e.k, tv))
          check("known_byte", oTD_DATA, tv, e.k);
        if (e.is_rst) begin
          last_fs = -1;
        end else if (oFRAME_START) begin
          if (last_fs >= 0) check("frame_period", n - last_fs, FR, e.k);
          last_fs = n;
        end
      end
    end
  end

  initial begin
    pix.iYCbCr = 16'h0000;
    pix.iDVAL  = 1'b0;
    dir_q = '{16'h5A80, 16'hEBF0, 16'hFF00, 16'h0000, 16'hFFFF};
    repeat (3) cycle();
    rst_req = 0;
    run_to(99*LB + 7);
    en_req = 0;
    run_to(FR + 300*LB);
    en_req = 1;
    run_to(2*FR + 24*LB + ACT0 + 9);
    rst_req = 1;
    repeat (2) cycle();
    rst_req = 0;
    run_to(35*LB);
    rand_gap = 1;
    run_to(42*LB);
    @(negedge iCLK);
    #3;
    check("queue_drained", q.size(), 0, k);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
